// File: rtl/memory_access_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_pkg
// Shared definitions for the uDLX MEM stage:
//   - state_e  : access FSM encoding (ST_IDLE, ST_WAIT)
//   - NOP_INSTR: instruction word loaded into MEM/WB for a bubble
// -----------------------------------------------------------------------------
package memory_access_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : memory_access_pkg

// File: rtl/memory_access_pipe.sv
// -----------------------------------------------------------------------------
// memory_pipe
// MEM/WB pipeline register. When load_en_i is high the register captures the
// incoming fields, or a bubble (all fields 0) when flush_i is also high.
// Otherwise it holds its contents.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           load a bubble instead of the inputs
//   load_en_i         capture enable
//   *_i               values to capture
//   *_o               registered MEM/WB outputs
// -----------------------------------------------------------------------------
module memory_pipe
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         load_en_i,
  input  logic [DATA_WIDTH-1:0]        mem_data_i,
  input  logic [DATA_WIDTH-1:0]        alu_data_i,
  input  logic                         reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_i,
  input  logic                         wb_sel_i,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0]        mem_data_o,
  output logic [DATA_WIDTH-1:0]        alu_data_o,
  output logic                         reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_o,
  output logic                         wb_sel_o,
  output logic [INSTRUCTION_WIDTH-1:0] instr_o
);

  logic [DATA_WIDTH-1:0]        mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0]        alu_data_q, alu_data_d;
  logic                         reg_wr_en_q, reg_wr_en_d;
  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_q, reg_wr_addr_d;
  logic                         wb_sel_q, wb_sel_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;

  // Next-state selection: hold, capture inputs, or capture a bubble.
  always_comb begin
    mem_data_d    = mem_data_q;
    alu_data_d    = alu_data_q;
    reg_wr_en_d   = reg_wr_en_q;
    reg_wr_addr_d = reg_wr_addr_q;
    wb_sel_d      = wb_sel_q;
    instr_d       = instr_q;
    if (load_en_i) begin
      if (flush_i) begin
        mem_data_d    = '0;
        alu_data_d    = '0;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = '0;
        wb_sel_d      = 1'b0;
        instr_d       = INSTRUCTION_WIDTH'(NOP_INSTR);
      end else begin
        mem_data_d    = mem_data_i;
        alu_data_d    = alu_data_i;
        reg_wr_en_d   = reg_wr_en_i;
        reg_wr_addr_d = reg_wr_addr_i;
        wb_sel_d      = wb_sel_i;
        instr_d       = instr_i;
      end
    end else begin
      mem_data_d = mem_data_q;
    end
  end

  // MEM/WB register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data_q    <= '0;
      alu_data_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      wb_sel_q      <= 1'b0;
      instr_q       <= '0;
    end else begin
      mem_data_q    <= mem_data_d;
      alu_data_q    <= alu_data_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      wb_sel_q      <= wb_sel_d;
      instr_q       <= instr_d;
    end
  end

  assign mem_data_o    = mem_data_q;
  assign alu_data_o    = alu_data_q;
  assign reg_wr_en_o   = reg_wr_en_q;
  assign reg_wr_addr_o = reg_wr_addr_q;
  assign wb_sel_o      = wb_sel_q;
  assign instr_o       = instr_q;

endmodule : memory_pipe

// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
// MEM stage of the uDLX pipeline. Issues data-memory requests for loads and
// stores coming out of EX/MEM, stalls upstream while an access is in flight,
// and loads the MEM/WB register (memory_pipe) feeding write-back.
// Non-memory instructions pass through with one cycle of latency.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      turn the instruction leaving this stage into a bubble
//   mem_data_rd_en_in/wr_en_in load/store request; store wins if both set
//   mem_data_in, alu_data_in   store data, ALU result (= address)
//   reg_wr_*_in, write_back_mux_sel_in, instruction_in   forwarded to MEM/WB
//   dmem_req/we/addr/wdata     registered memory request port
//   dmem_rdata, dmem_ack       memory response (ack is a one-cycle pulse)
//   stall_out                  combinational upstream hold
//   *_out                      registered MEM/WB outputs
//   mem_error_out              sticky ack-timeout flag
//
// Configuration: define MEM_ACCESS_TIMEOUT_EN to build an ack watchdog that
// abandons an access after TIMEOUT_CYCLES wait cycles. Without it the stage
// waits indefinitely and mem_error_out is tied to 0.
// -----------------------------------------------------------------------------
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         mem_data_rd_en_in,
  input  logic                         mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]        mem_data_in,
  input  logic [DATA_WIDTH-1:0]        alu_data_in,
  input  logic                         reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_in,
  input  logic                         write_back_mux_sel_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  output logic                         dmem_req,
  output logic                         dmem_we,
  output logic [DATA_WIDTH-1:0]        dmem_addr,
  output logic [DATA_WIDTH-1:0]        dmem_wdata,
  input  logic [DATA_WIDTH-1:0]        dmem_rdata,
  input  logic                         dmem_ack,
  output logic                         stall_out,
  output logic [DATA_WIDTH-1:0]        mem_data_out,
  output logic [DATA_WIDTH-1:0]        alu_data_out,
  output logic                         reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic                         write_back_mux_sel_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic                         mem_error_out
);

  state_e                  state_q, state_d;
  logic                    req_we_q, req_we_d;
  logic [DATA_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  // Remembers a flush seen while waiting, so the completing access becomes a bubble.
  logic                    flushed_q, flushed_d;

  logic                    access_s;
  logic                    stall_s;
  logic                    load_en_s;
  logic                    bubble_s;
  logic                    timeout_s;
  logic [DATA_WIDTH-1:0]   wb_mem_data_s;

  assign access_s = mem_data_rd_en_in | mem_data_wr_en_in;

  // Access FSM: request capture, completion, stall and MEM/WB load control.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    flushed_d   = flushed_q;
    stall_s     = 1'b0;
    load_en_s   = 1'b0;
    bubble_s    = flush;
    case (state_q)
      ST_IDLE: begin
        // A flushed request is never issued; it just becomes a bubble.
        if (access_s && !flush) begin
          state_d     = ST_WAIT;
          req_we_d    = mem_data_wr_en_in;
          req_addr_d  = alu_data_in;
          req_wdata_d = mem_data_in;
          flushed_d   = 1'b0;
          stall_s     = 1'b1;
        end else begin
          load_en_s = 1'b1;
          bubble_s  = flush;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_d   = ST_IDLE;
          load_en_s = 1'b1;
          bubble_s  = flush | flushed_q;
          flushed_d = 1'b0;
        end else if (timeout_s) begin
          state_d   = ST_IDLE;
          load_en_s = 1'b1;
          bubble_s  = 1'b1;
          flushed_d = 1'b0;
        end else begin
          stall_s   = 1'b1;
          flushed_d = flushed_q | flush;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        flushed_d = 1'b0;
      end
    endcase
  end

  // FSM state and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      flushed_q   <= flushed_d;
    end
  end

  assign dmem_req   = (state_q == ST_WAIT);
  assign dmem_we    = req_we_q;
  assign dmem_addr  = req_addr_q;
  assign dmem_wdata = req_wdata_q;
  // Reset forces the stall low immediately, even if upstream still requests.
  assign stall_out  = stall_s & rst_n;

  // Only a completing load delivers memory data; stores and ALU ops carry 0.
  assign wb_mem_data_s = ((state_q == ST_WAIT) && !req_we_q) ? dmem_rdata : '0;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;

  // Ack watchdog: counts wait cycles, fires on the last allowed one.
  always_comb begin
    wd_cnt_d  = '0;
    err_d     = err_q;
    timeout_s = 1'b0;
    if ((state_q == ST_WAIT) && !dmem_ack) begin
      if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_s = 1'b1;
        err_d     = 1'b1;
        wd_cnt_d  = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end
    end else begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign mem_error_out = err_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = TIMEOUT_CYCLES[0];
  assign timeout_s        = 1'b0;
  assign mem_error_out    = 1'b0;
`endif

  memory_pipe #(
    .DATA_WIDTH        (DATA_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .REG_ADDR_WIDTH    (REG_ADDR_WIDTH)
  ) u_memory_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (bubble_s),
    .load_en_i     (load_en_s),
    .mem_data_i    (wb_mem_data_s),
    .alu_data_i    (alu_data_in),
    .reg_wr_en_i   (reg_wr_en_in),
    .reg_wr_addr_i (reg_wr_addr_in),
    .wb_sel_i      (write_back_mux_sel_in),
    .instr_i       (instruction_in),
    .mem_data_o    (mem_data_out),
    .alu_data_o    (alu_data_out),
    .reg_wr_en_o   (reg_wr_en_out),
    .reg_wr_addr_o (reg_wr_addr_out),
    .wb_sel_o      (write_back_mux_sel_out),
    .instr_o       (instruction_out)
  );

endmodule : memory_access

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
// Directed self-checking bench for memory_access. Inputs change and outputs
// are sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        rd_en, wr_en;
  logic [31:0] mem_data_in, alu_data_in;
  logic        reg_wr_en_in;
  logic [4:0]  reg_wr_addr_in;
  logic        wb_sel_in;
  logic [31:0] instr_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall_out;
  logic [31:0] mem_data_out, alu_data_out;
  logic        reg_wr_en_out;
  logic [4:0]  reg_wr_addr_out;
  logic        wb_sel_out;
  logic [31:0] instr_out;
  logic        mem_error_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access #(
    .DATA_WIDTH(32), .INSTRUCTION_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .flush                  (flush),
    .mem_data_rd_en_in      (rd_en),
    .mem_data_wr_en_in      (wr_en),
    .mem_data_in            (mem_data_in),
    .alu_data_in            (alu_data_in),
    .reg_wr_en_in           (reg_wr_en_in),
    .reg_wr_addr_in         (reg_wr_addr_in),
    .write_back_mux_sel_in  (wb_sel_in),
    .instruction_in         (instr_in),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_rdata             (dmem_rdata),
    .dmem_ack               (dmem_ack),
    .stall_out              (stall_out),
    .mem_data_out           (mem_data_out),
    .alu_data_out           (alu_data_out),
    .reg_wr_en_out          (reg_wr_en_out),
    .reg_wr_addr_out        (reg_wr_addr_out),
    .write_back_mux_sel_out (wb_sel_out),
    .instruction_out        (instr_out),
    .mem_error_out          (mem_error_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    mem_data_in = 32'h0; alu_data_in = 32'h0;
    reg_wr_en_in = 1'b0; reg_wr_addr_in = 5'd0; wb_sel_in = 1'b0; instr_in = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] ins);
    rd_en = 1'b1; wr_en = 1'b0; alu_data_in = addr; mem_data_in = 32'h0;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = rd; wb_sel_in = 1'b1; instr_in = ins;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_stall", {63'd0, stall_out}, 64'd0);
    chk("rst_alu", {32'd0, alu_data_out}, 64'd0);
    chk("rst_wben", {63'd0, reg_wr_en_out}, 64'd0);
    chk("rst_err", {63'd0, mem_error_out}, 64'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- 1: ALU pass-through ----------------
    alu_data_in = 32'h1234; reg_wr_addr_in = 5'd5; reg_wr_en_in = 1'b1; instr_in = 32'h1111_1111;
    #1 chk("alu_stall", {63'd0, stall_out}, 64'd0);
    tick();
    chk("alu_data", {32'd0, alu_data_out}, 64'h1234);
    chk("alu_rd", {59'd0, reg_wr_addr_out}, 64'd5);
    chk("alu_wben", {63'd0, reg_wr_en_out}, 64'd1);
    chk("alu_instr", {32'd0, instr_out}, 64'h1111_1111);
    chk("alu_req", {63'd0, dmem_req}, 64'd0);
    chk("alu_stall2", {63'd0, stall_out}, 64'd0);
    idle_inputs();
    tick();

    // ---------------- 2: load, ack 3 cycles after req ----------------
    set_load(32'h40, 5'd7, 32'h2222_2222);
    #1 chk("ld_stall_idle", {63'd0, stall_out}, 64'd1);
    chk("ld_req_early", {63'd0, dmem_req}, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", {63'd0, dmem_req}, 64'd1);
      chk("ld_we", {63'd0, dmem_we}, 64'd0);
      chk("ld_addr", {32'd0, dmem_addr}, 64'h40);
      chk("ld_stall", {63'd0, stall_out}, 64'd1);
      if (i < 2) tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_stall_ack", {63'd0, stall_out}, 64'd0);
    tick();
    idle_inputs();
    chk("ld_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("ld_mdata", {32'd0, mem_data_out}, 64'hDEAD_BEEF);
    chk("ld_wbsel", {63'd0, wb_sel_out}, 64'd1);
    chk("ld_rd", {59'd0, reg_wr_addr_out}, 64'd7);
    chk("ld_alu", {32'd0, alu_data_out}, 64'h40);
    tick();

    // ---------------- 3: store, ack after 1 cycle ----------------
    wr_en = 1'b1; mem_data_in = 32'hA5A5_A5A5; alu_data_in = 32'h80;
    reg_wr_en_in = 1'b0; instr_in = 32'h3333_3333;
    #1 chk("st_stall_idle", {63'd0, stall_out}, 64'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("st_req", {63'd0, dmem_req}, 64'd1);
      chk("st_we", {63'd0, dmem_we}, 64'd1);
      chk("st_addr", {32'd0, dmem_addr}, 64'h80);
      chk("st_wdata", {32'd0, dmem_wdata}, 64'hA5A5_A5A5);
      if (i == 0) tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    chk("st_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("st_wben", {63'd0, reg_wr_en_out}, 64'd0);
    chk("st_mdata", {32'd0, mem_data_out}, 64'd0);
    chk("st_instr", {32'd0, instr_out}, 64'h3333_3333);
    tick();

    // ---------------- 3b: rd and wr both set -> store ----------------
    set_load(32'h84, 5'd3, 32'h3B3B_3B3B);
    wr_en = 1'b1; mem_data_in = 32'h0F0F_0F0F;
    tick();
    chk("rw_we", {63'd0, dmem_we}, 64'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    idle_inputs();
    chk("rw_mdata", {32'd0, mem_data_out}, 64'd0);
    tick();

    // ---------------- 4: flush during WAIT of a load ----------------
    set_load(32'h44, 5'd9, 32'h4444_4444);
    tick();
    flush = 1'b1;
    #1 chk("fl_stall", {63'd0, stall_out}, 64'd1);
    tick();
    flush = 1'b0;
    chk("fl_req_held", {63'd0, dmem_req}, 64'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    idle_inputs();
    chk("fl_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("fl_wben", {63'd0, reg_wr_en_out}, 64'd0);
    chk("fl_wbsel", {63'd0, wb_sel_out}, 64'd0);
    chk("fl_instr", {32'd0, instr_out}, 64'd0);
    chk("fl_mdata", {32'd0, mem_data_out}, 64'd0);
    tick();

    // ---------------- 4b: flush with new request in IDLE ----------------
    set_load(32'h48, 5'd10, 32'h4B4B_4B4B);
    flush = 1'b1;
    #1 chk("fli_stall", {63'd0, stall_out}, 64'd0);
    tick();
    idle_inputs();
    chk("fli_req", {63'd0, dmem_req}, 64'd0);
    chk("fli_wben", {63'd0, reg_wr_en_out}, 64'd0);
    tick();

    // ---------------- 5: reset during WAIT ----------------
    set_load(32'h50, 5'd11, 32'h5555_0000);
    tick();
    chk("rw_req_pre", {63'd0, dmem_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rsw_req", {63'd0, dmem_req}, 64'd0);
    chk("rsw_stall", {63'd0, stall_out}, 64'd0);
    tick();
    idle_inputs();
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    chk("rsw_late_req", {63'd0, dmem_req}, 64'd0);
    chk("rsw_late_mdata", {32'd0, mem_data_out}, 64'd0);
    chk("rsw_late_wben", {63'd0, reg_wr_en_out}, 64'd0);
    tick();

    // ---------------- 6: long wait / timeout ----------------
    set_load(32'h60, 5'd12, 32'h6666_6666);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_req_held", {63'd0, dmem_req}, 64'd1);
      tick();
    end
`ifdef MEM_ACCESS_TIMEOUT_EN
    idle_inputs();
    chk("to_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("to_err", {63'd0, mem_error_out}, 64'd1);
    chk("to_wben", {63'd0, reg_wr_en_out}, 64'd0);
    chk("to_instr", {32'd0, instr_out}, 64'd0);
    tick(); tick();
    chk("to_err_sticky", {63'd0, mem_error_out}, 64'd1);
`else
    // Without the watchdog the access keeps waiting past 8 cycles.
    chk("nto_req_held", {63'd0, dmem_req}, 64'd1);
    chk("nto_err", {63'd0, mem_error_out}, 64'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_CAFE;
    tick();
    idle_inputs();
    chk("nto_mdata", {32'd0, mem_data_out}, 64'h0BAD_CAFE);
    chk("nto_wben", {63'd0, reg_wr_en_out}, 64'd1);
    chk("nto_err2", {63'd0, mem_error_out}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_memory_access
